// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start detection, mid-bit sampling and
// frame assembly into an 11-bit parallel word with parity/stop error flags.
`timescale 1ns/1ps

module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_en,
  input  logic        baud_tick,
  input  logic        rx_in,
  output logic [10:0] data_parll,
  output logic        frame_valid,
  output logic [7:0]  data_out,
  output logic        parity_err,
  output logic        stop_err,
  output logic        busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_next;

  logic          rx_m, rx_s, rx_prev;
  logic [TW-1:0] tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    data_sh;
  logic          par_bit;
  logic          fall, mid_tick, end_tick, stop_done;

  assign fall      = rx_prev & ~rx_s;
  assign mid_tick  = baud_tick && (tcnt == T_MID);
  assign end_tick  = baud_tick && (tcnt == T_LAST);
  assign stop_done = rx_en && (state == STOP) && end_tick;
  assign data_out  = data_parll[8:1];

  // Synchronizer plus one extra stage so the start edge is seen on clean samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx_in;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall) state_next = START;
      START:   if (mid_tick) state_next = rx_s ? IDLE : DATA;
      DATA:    if (end_tick && (bcnt == 3'd7)) state_next = PARITY;
      PARITY:  if (end_tick) state_next = STOP;
      STOP:    if (end_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!rx_en) state_next = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // The start phase only runs to mid-bit, so later samples land mid-bit too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      bcnt <= '0;
    end else if (!rx_en || (state == IDLE)) begin
      tcnt <= '0;
      bcnt <= '0;
    end else if (baud_tick) begin
      case (state)
        START: begin
          tcnt <= (tcnt == T_MID) ? '0 : tcnt + TW'(1);
          bcnt <= '0;
        end
        DATA: begin
          if (tcnt == T_LAST) begin
            tcnt <= '0;
            if (bcnt != 3'd7) bcnt <= bcnt + 3'd1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: tcnt <= (tcnt == T_LAST) ? '0 : tcnt + TW'(1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sh <= '0;
      par_bit <= 1'b0;
    end else if (rx_en && end_tick) begin
      if (state == DATA)   data_sh <= {rx_s, data_sh[7:1]};
      if (state == PARITY) par_bit <= rx_s;
    end
  end

  // Published outputs change only when a complete frame is delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_parll  <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      stop_err    <= 1'b0;
    end else begin
      frame_valid <= stop_done;
      if (stop_done) begin
        data_parll <= {rx_s, par_bit, data_sh, 1'b0};
        parity_err <= (^{par_bit, data_sh}) ^ PARITY_ODD;
        stop_err   <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames push hand-computed
// expectations; a monitor pops and compares on every frame_valid.
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

  localparam int OS       = 16;
  localparam int TICK_DIV = 3;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic        clk = 1'b0;
  logic        rst_n, rx_en, baud_tick, rx_in;
  logic [10:0] data_parll;
  logic        frame_valid, parity_err, stop_err, busy;
  logic [7:0]  data_out;

  typedef struct packed {
    logic [10:0] parll;
    logic        pe;
    logic        se;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tick_cnt;
  logic fv_prev = 1'b0;

  uart_rx_ctrl #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .baud_tick(baud_tick),
    .rx_in(rx_in), .data_parll(data_parll), .frame_valid(frame_valid),
    .data_out(data_out), .parity_err(parity_err), .stop_err(stop_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // baud_tick every TICK_DIV clocks
  initial begin
    tick_cnt  = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = (tick_cnt == TICK_DIV - 1);
      tick_cnt  = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stp,
                               input logic [10:0] exp_parll, input logic exp_pe,
                               input logic exp_se);
    exp_t e;
    e.parll = exp_parll;
    e.pe    = exp_pe;
    e.se    = exp_se;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  // Monitor: every frame_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (frame_valid) begin
      checkOutput("fv_single_cycle", {10'd0, fv_prev}, 11'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_frame: got data_parll 'h%0h, expected no frame at %0t",
                 data_parll, $time);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("data_parll", data_parll, mon_e.parll);
        checkOutput("data_out", {3'd0, data_out}, {3'd0, mon_e.parll[8:1]});
        checkOutput("parity_err", {10'd0, parity_err}, {10'd0, mon_e.pe});
        checkOutput("stop_err", {10'd0, stop_err}, {10'd0, mon_e.se});
      end
    end
    fv_prev = frame_valid;
  end

  task automatic check_reset_values();
    checkOutput("rst_data_parll", data_parll, 11'h000);
    checkOutput("rst_data_out", {3'd0, data_out}, 11'h000);
    checkOutput("rst_frame_valid", {10'd0, frame_valid}, 11'd0);
    checkOutput("rst_parity_err", {10'd0, parity_err}, 11'd0);
    checkOutput("rst_stop_err", {10'd0, stop_err}, 11'd0);
    checkOutput("rst_busy", {10'd0, busy}, 11'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_en = 1'b0;
    rx_in = 1'b1;
    wait_clks(5);
    check_reset_values();
    rst_n = 1'b1;
    rx_en = 1'b1;
    wait_clks(BIT_CLKS);

    applyStimulus(8'hA5, 1'b0, 1'b1, 11'h54A, 1'b0, 1'b0);
    drive_bit(1'b1);
    applyStimulus(8'hA5, 1'b1, 1'b1, 11'h74A, 1'b1, 1'b0);
    drive_bit(1'b1);

    // stop error, line stays low afterwards
    applyStimulus(8'h3C, 1'b0, 1'b0, 11'h078, 1'b0, 1'b1);
    wait_clks(3 * BIT_CLKS);
    checkOutput("low_line_busy", {10'd0, busy}, 11'd0);
    checkOutput("low_line_hold", data_parll, 11'h078);
    drive_bit(1'b1);
    applyStimulus(8'h01, 1'b1, 1'b1, 11'h602, 1'b0, 1'b0);
    drive_bit(1'b1);

    // 4-tick glitch: false start
    rx_in = 1'b0;
    wait_clks(4 * TICK_DIV);
    rx_in = 1'b1;
    wait_clks(4);
    checkOutput("glitch_busy_rise", {10'd0, busy}, 11'd1);
    wait_clks(BIT_CLKS);
    checkOutput("glitch_busy_drop", {10'd0, busy}, 11'd0);
    checkOutput("glitch_hold", data_parll, 11'h602);

    // abort 0x5A during data bit 4 with rx_en
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx_in = 1'b1;
    wait_clks(20);
    checkOutput("abort_busy_before", {10'd0, busy}, 11'd1);
    rx_en = 1'b0;
    wait_clks(1);
    checkOutput("abort_busy_after", {10'd0, busy}, 11'd0);
    wait_clks(BIT_CLKS - 21);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx_en = 1'b1;
    wait_clks(BIT_CLKS);
    checkOutput("abort_hold", data_parll, 11'h602);
    applyStimulus(8'hFF, 1'b0, 1'b1, 11'h5FE, 1'b0, 1'b0);
    drive_bit(1'b1);

    // reset during parity of 0x5A
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d5a;
      d5a = 8'h5A;
      drive_bit(d5a[i]);
    end
    rx_in = 1'b0;
    wait_clks(BIT_CLKS / 2);
    checkOutput("parity_busy", {10'd0, busy}, 11'd1);
    rst_n = 1'b0;
    wait_clks(1);
    check_reset_values();
    rx_in = 1'b1;
    wait_clks(BIT_CLKS);
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);
    applyStimulus(8'h00, 1'b0, 1'b1, 11'h400, 1'b0, 1'b0);
    drive_bit(1'b1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_clks(1);
    checkOutput("pending_frames", 11'(exp_q.size()), 11'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
